// File: rtl/psm_carrier_sync_gen_if.sv
// Control and carrier/sync bundle for psm_carrier_sync_gen.
// master drives run/load requests; slave (the generator) returns ack, carriers and sync pulses.
interface psm_carrier_sync_gen_if #(
  parameter int BITS_DATA = 16,
  parameter int CHANNELS  = 2
);
  logic                          iEN;
  logic [BITS_DATA-1:0]          iFREQUENCY;
  logic [CHANNELS*BITS_DATA-1:0] iPHASE;
  logic                          iLOAD;
  logic                          oLOAD_ack;
  logic [CHANNELS*BITS_DATA-1:0] oCNT;
  logic [CHANNELS-1:0]           oSYNC;

  modport master (
    output iEN, iFREQUENCY, iPHASE, iLOAD,
    input  oLOAD_ack, oCNT, oSYNC
  );

  modport slave (
    input  iEN, iFREQUENCY, iPHASE, iLOAD,
    output oLOAD_ack, oCNT, oSYNC
  );
endinterface

// File: rtl/psm_carrier_sync_gen.sv
// Multi-channel phase-shifted carrier and sync generator with period-boundary double buffering.
// Define PSM_CARRIER_UPDOWN_EN for a triangular (up-down) carrier; default build is sawtooth.
module psm_carrier_sync_gen #(
  parameter int BITS_DATA = 16,
  parameter int CHANNELS  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  psm_carrier_sync_gen_if.slave bus
);
`ifdef PSM_CARRIER_UPDOWN_EN
  localparam int MW = BITS_DATA + 1;
`else
  localparam int MW = BITS_DATA;
`endif
  localparam logic [MW-1:0] M_ONE = MW'(1);

  logic [MW-1:0]                 r_m;
  logic [BITS_DATA-1:0]          r_fa;
  logic [BITS_DATA-1:0]          r_pa [CHANNELS];
  logic                          r_pend;
  logic                          r_ack;
  logic [CHANNELS*BITS_DATA-1:0] r_cnt;
  logic [CHANNELS-1:0]           r_sync;

  logic                          w_idle;
  logic                          w_last;
  logic                          w_xfer;
  logic [CHANNELS*BITS_DATA-1:0] w_cnt;
  logic [CHANNELS-1:0]           w_sync;

  // Saturate a requested phase to the last position of a period of terminal count f.
  function automatic logic [BITS_DATA-1:0] f_clamp(input logic [BITS_DATA-1:0] p,
                                                   input logic [BITS_DATA-1:0] f);
`ifdef PSM_CARRIER_UPDOWN_EN
    logic [BITS_DATA:0] lim;
    lim = {f, 1'b0} - {{BITS_DATA{1'b0}}, 1'b1};
    if (f == '0) return '0;
    return ({1'b0, p} > lim) ? lim[BITS_DATA-1:0] : p;
`else
    return (p > f) ? f : p;
`endif
  endfunction

  // Phase-shifted position within the period; single conditional subtract suffices
  // because both m and the clamped phase are below one period.
  function automatic logic [MW-1:0] f_wrap(input logic [MW-1:0]        m,
                                           input logic [BITS_DATA-1:0] p,
                                           input logic [BITS_DATA-1:0] f);
`ifdef PSM_CARRIER_UPDOWN_EN
    logic [BITS_DATA+1:0] s;
    logic [BITS_DATA+1:0] per;
    per = {1'b0, f, 1'b0};
    s   = {1'b0, m} + {2'b00, p};
    if (s >= per) s = s - per;
    return s[MW-1:0];
`else
    logic [BITS_DATA:0] s;
    logic [BITS_DATA:0] wrap;
    wrap = {1'b0, f} + {{BITS_DATA{1'b0}}, 1'b1};
    s    = {1'b0, m} + {1'b0, p};
    if (s > {1'b0, f}) s = s - wrap;
    return s[MW-1:0];
`endif
  endfunction

`ifdef PSM_CARRIER_UPDOWN_EN
  function automatic logic [BITS_DATA-1:0] f_fold(input logic [MW-1:0]        v,
                                                  input logic [BITS_DATA-1:0] f);
    return (v <= {1'b0, f}) ? v[BITS_DATA-1:0] : BITS_DATA'({f, 1'b0} - v);
  endfunction
`endif

  assign w_idle = !bus.iEN || (r_fa == '0);
`ifdef PSM_CARRIER_UPDOWN_EN
  assign w_last = (r_m == ({r_fa, 1'b0} - M_ONE));
`else
  assign w_last = (r_m == r_fa);
`endif
  assign w_xfer = (r_pend || bus.iLOAD) && (w_idle || w_last);

  always_comb begin
    logic [MW-1:0] v;
    v      = '0;
    w_cnt  = '0;
    w_sync = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      v = f_wrap(r_m, r_pa[k], r_fa);
`ifdef PSM_CARRIER_UPDOWN_EN
      w_cnt[k*BITS_DATA +: BITS_DATA] = f_fold(v, r_fa);
      w_sync[k] = (v == {1'b0, r_fa});
`else
      w_cnt[k*BITS_DATA +: BITS_DATA] = v;
      w_sync[k] = (v == r_fa);
`endif
    end
  end

  // Carrier outputs are taken from the pre-update position, so a transfer at the last
  // position still emits the final sample of the old period before m returns to 0.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_m    <= '0;
      r_fa   <= '0;
      r_pend <= 1'b0;
      r_ack  <= 1'b0;
      r_cnt  <= '0;
      r_sync <= '0;
      for (int k = 0; k < CHANNELS; k++) r_pa[k] <= '0;
    end else begin
      r_ack  <= w_xfer;
      r_pend <= w_xfer ? 1'b0 : (r_pend | bus.iLOAD);
      if (w_xfer) begin
        r_fa <= bus.iFREQUENCY;
        for (int k = 0; k < CHANNELS; k++)
          r_pa[k] <= f_clamp(bus.iPHASE[k*BITS_DATA +: BITS_DATA], bus.iFREQUENCY);
      end
      if (w_idle) begin
        r_m    <= '0;
        r_cnt  <= '0;
        r_sync <= '0;
      end else begin
        r_m    <= w_last ? '0 : r_m + M_ONE;
        r_cnt  <= w_cnt;
        r_sync <= w_sync;
      end
    end
  end

  assign bus.oLOAD_ack = r_ack;
  assign bus.oCNT      = r_cnt;
  assign bus.oSYNC     = r_sync;
endmodule
